// File: rtl/imem_loader_pkg.sv
// Shared types and helpers for the instruction-memory byte-stream loader.
package imem_loader_pkg;

    // Loader FSM states: wait for sync, read word count, collect bytes,
    // write one word, then compare the frame checksum.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_WR   = 3'd3,
        S_CSUM = 3'd4
    } loader_state_t;

    // Default frame start byte.
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Number of stream bytes that make up one instruction word.
    function automatic int bytes_per_word(input int instr_w);
        return instr_w / 8;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles framed bytes into instruction words,
// writes them into imem from address 0 upward, verifies the frame checksum
// and only lets the processing unit run after a cleanly loaded frame.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         INSTR_W = 16,
    parameter int         ADDR_W  = 8,
    parameter logic [7:0] SYNC    = SYNC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         i_data,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_mem_we,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic [INSTR_W-1:0] o_mem_wd,
    output logic               o_pu_run,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam int         BPW       = bytes_per_word(INSTR_W);
    localparam logic [1:0] LAST_BYTE = 2'(BPW - 1);

    loader_state_t       r_state;
    logic [7:0]          r_len;
    logic [7:0]          r_word_cnt;
    logic [1:0]          r_byte_cnt;
    logic [7:0]          r_acc;
    logic [INSTR_W-1:0]  r_word;
    logic [ADDR_W-1:0]   r_addr;

    logic                w_xfer;
    logic [INSTR_W-1:0]  w_word_next;
    logic [7:0]          w_cnt_next;

    // A byte moves only when the source offers it and the loader can take it.
    assign w_xfer = i_valid & o_ready;

    // New byte enters at the bottom; the oldest byte falls off the top, so
    // after BPW bytes the first byte received sits in the MSBs.
    assign w_word_next = INSTR_W'({r_word, i_data});

    // Word count after the word currently being written.
    assign w_cnt_next = r_word_cnt + 8'd1;

    // Frame FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_acc      <= '0;
            r_word     <= '0;
            r_addr     <= '0;
            o_ready    <= 1'b1;
            o_mem_we   <= 1'b0;
            o_mem_addr <= '0;
            o_mem_wd   <= '0;
            o_pu_run   <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            o_mem_we <= 1'b0;
            o_done   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer && (i_data == SYNC)) begin
                        r_state  <= S_LEN;
                        r_addr   <= '0;
                        o_pu_run <= 1'b0;
                        o_err    <= 1'b0;
                        o_busy   <= 1'b1;
                    end
                end

                S_LEN: begin
                    if (w_xfer) begin
                        r_len      <= i_data;
                        r_acc      <= i_data;
                        r_word_cnt <= '0;
                        r_byte_cnt <= '0;
                        if (i_data == 8'd0) begin
                            r_state <= S_CSUM;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (w_xfer) begin
                        r_acc  <= r_acc + i_data;
                        r_word <= w_word_next;
                        if (r_byte_cnt == LAST_BYTE) begin
                            r_byte_cnt <= '0;
                            r_state    <= S_WR;
                            o_ready    <= 1'b0;
                            o_mem_we   <= 1'b1;
                            o_mem_wd   <= w_word_next;
                            o_mem_addr <= r_addr;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end

                S_WR: begin
                    r_addr     <= r_addr + ADDR_W'(1);
                    r_word_cnt <= w_cnt_next;
                    o_ready    <= 1'b1;
                    if (w_cnt_next == r_len) begin
                        r_state <= S_CSUM;
                    end else begin
                        r_state <= S_DATA;
                    end
                end

                S_CSUM: begin
                    if (w_xfer) begin
                        if (i_data == r_acc) begin
                            o_pu_run <= 1'b1;
                            o_done   <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    o_ready <= 1'b1;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: frames are built from
// word lists, and expected writes, checksum outcome and handshake bubbles
// come from a frame-level model of the byte format.
module tb_imem_loader;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         i_data = 8'h00;
    logic               i_valid = 1'b0;
    logic               o_ready;
    logic               o_mem_we;
    logic [ADDR_W-1:0]  o_mem_addr;
    logic [INSTR_W-1:0] o_mem_wd;
    logic               o_pu_run;
    logic               o_busy;
    logic               o_done;
    logic               o_err;

    int total = 0;
    int bad = 0;

    logic [15:0]       frameWords[$];
    logic [ADDR_W-1:0] obsAddr[$];
    logic [15:0]       obsData[$];
    int                doneCnt = 0;
    int                readyLowCnt = 0;

    imem_loader #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_wd   (o_mem_wd),
        .o_pu_run   (o_pu_run),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Observe memory writes, done pulses and handshake bubbles mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_mem_we) begin
                obsAddr.push_back(o_mem_addr);
                obsData.push_back(o_mem_wd);
            end
            if (o_done) doneCnt++;
            if (!o_ready) readyLowCnt++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    // Offer one byte after a random idle gap and hold it until accepted.
    task automatic applyStimulus(input logic [7:0] b, input int maxGap);
        int gap;
        int waited;
        gap = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
        repeat (gap) begin
            @(negedge clk);
            i_valid = 1'b0;
        end
        @(negedge clk);
        i_data  = b;
        i_valid = 1'b1;
        waited  = 0;
        while (!o_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 10) checkOutput("readyTimeout", 32'(waited), 32'd0);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Send a whole frame for frameWords and check everything it should cause.
    task automatic runFrame(input bit corrupt, input int maxGap);
        int         n;
        logic [7:0] sum;
        logic [7:0] nb;
        n  = frameWords.size();
        nb = 8'(n);
        obsAddr.delete();
        obsData.delete();
        doneCnt     = 0;
        readyLowCnt = 0;

        applyStimulus(8'hA5, maxGap);
        checkOutput("runDropOnSync", 32'(o_pu_run), 32'd0);
        checkOutput("errClearOnSync", 32'(o_err), 32'd0);
        checkOutput("busyAfterSync", 32'(o_busy), 32'd1);

        sum = nb;
        applyStimulus(nb, maxGap);
        foreach (frameWords[i]) begin
            sum = sum + frameWords[i][15:8] + frameWords[i][7:0];
            applyStimulus(frameWords[i][15:8], maxGap);
            applyStimulus(frameWords[i][7:0], maxGap);
        end
        applyStimulus(corrupt ? sum + 8'd1 : sum, maxGap);
        repeat (2) @(negedge clk);

        checkOutput("writeCount", 32'(obsAddr.size()), 32'(n));
        for (int i = 0; i < n && i < obsAddr.size(); i++) begin
            checkOutput("writeAddr", 32'(obsAddr[i]), 32'(i % 256));
            checkOutput("writeData", 32'(obsData[i]), 32'(frameWords[i]));
        end
        checkOutput("donePulses", 32'(doneCnt), corrupt ? 32'd0 : 32'd1);
        checkOutput("errFlag", 32'(o_err), corrupt ? 32'd1 : 32'd0);
        checkOutput("puRun", 32'(o_pu_run), corrupt ? 32'd0 : 32'd1);
        checkOutput("readyBubbles", 32'(readyLowCnt), 32'(n));
        checkOutput("busyIdle", 32'(o_busy), 32'd0);
        if (n > 0) begin
            checkOutput("addrHold", 32'(o_mem_addr), 32'((n - 1) % 256));
            checkOutput("dataHold", 32'(o_mem_wd), 32'(frameWords[n-1]));
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ready"}, 32'(o_ready), 32'd1);
        checkOutput({tag, "_we"}, 32'(o_mem_we), 32'd0);
        checkOutput({tag, "_addr"}, 32'(o_mem_addr), 32'd0);
        checkOutput({tag, "_wd"}, 32'(o_mem_wd), 32'd0);
        checkOutput({tag, "_run"}, 32'(o_pu_run), 32'd0);
        checkOutput({tag, "_busy"}, 32'(o_busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(o_done), 32'd0);
        checkOutput({tag, "_err"}, 32'(o_err), 32'd0);
    endtask

    initial begin
        logic [7:0] hi;
        logic [7:0] lo;
        int         len;

        repeat (3) @(negedge clk);
        checkResetOutputs("initReset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic two-word frame, back-to-back bytes.
        frameWords = '{16'h1234, 16'hABCD};
        runFrame(1'b0, 0);

        // Reset in the middle of DATA abandons the frame at once.
        frameWords = '{16'h1111, 16'h2222, 16'h3333};
        applyStimulus(8'hA5, 0);
        applyStimulus(8'h03, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h11, 0);
        applyStimulus(8'h22, 0);
        checkOutput("busyMidFrame", 32'(o_busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midReset");
        @(negedge clk);
        rst_n = 1'b1;
        runFrame(1'b0, 0);

        // Empty frame preceded by junk bytes.
        applyStimulus(8'h00, 0);
        applyStimulus(8'hFF, 0);
        checkOutput("junkIgnoredBusy", 32'(o_busy), 32'd0);
        frameWords.delete();
        runFrame(1'b0, 0);

        // Bad checksum, then a good frame must clear err on its SYNC.
        frameWords = '{16'h1234, 16'hABCD};
        runFrame(1'b1, 0);
        frameWords = '{16'hA5A5, 16'h00A5, 16'hA500};
        runFrame(1'b0, 2);

        // Random frames with gaps and frequent SYNC-valued data bytes.
        for (int f = 0; f < 8; f++) begin
            frameWords.delete();
            len = int'($urandom_range(6, 1));
            for (int k = 0; k < len; k++) begin
                hi = ($urandom_range(3, 0) == 0) ? 8'hA5 : 8'($urandom);
                lo = ($urandom_range(3, 0) == 0) ? 8'hA5 : 8'($urandom);
                frameWords.push_back({hi, lo});
            end
            runFrame(($urandom_range(2, 0) == 0), 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
